// File: rtl/priority_encoder_iter.sv
// Iterative priority encoder: holds a request vector and streams the indices of
// its set bits in priority order, clearing each one as the consumer accepts it.

module pe_tree #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);
  if (N == 4) begin : g_leaf
    always_comb begin
      found = |vec;
      idx   = IW'(3);
      if (vec[0])      idx = IW'(0);
      else if (vec[1]) idx = IW'(1);
      else if (vec[2]) idx = IW'(2);
    end
  end else begin : g_node
    localparam int Q = N / 4;
    logic [3:0]    sub_found;
    logic [IW-3:0] sub_idx [4];
    logic [1:0]    sel;

    for (genvar g = 0; g < 4; g++) begin : g_sub
      pe_tree #(.N(Q), .IW(IW - 2)) u_sub (
        .vec   (vec[g*Q +: Q]),
        .found (sub_found[g]),
        .idx   (sub_idx[g])
      );
    end

    // Lowest-numbered quarter holding a set bit wins.
    always_comb begin
      sel = 2'd3;
      if (sub_found[0])      sel = 2'd0;
      else if (sub_found[1]) sel = 2'd1;
      else if (sub_found[2]) sel = 2'd2;
    end

    assign found = |sub_found;
    assign idx   = {sel, sub_idx[sel]};
  end
endmodule

module priority_encoder_iter #(
  parameter int WIDTH     = 1024,
  parameter bit MSB_FIRST = 1'b0,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_all,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_last,
  output logic [IDX_W:0]   out_cnt
);
  function automatic int pad_width(input int w);
    int p;
    p = 4;
    while (p < w) p = p * 4;
    return p;
  endfunction

  localparam int             PW      = pad_width(WIDTH);
  localparam int             PIW     = $clog2(PW);
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] vec, vec_clr;
  logic             all_r;
  logic [IDX_W:0]   cnt;
  logic [PW-1:0]    tree_in;
  logic             tree_found;
  logic [PIW-1:0]   tree_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             load, accept;

  // Padding bits above WIDTH stay zero so they can never win the search.
  always_comb begin
    tree_in = '0;
    for (int i = 0; i < WIDTH; i++)
      tree_in[i] = MSB_FIRST ? vec[WIDTH-1-i] : vec[i];
  end

  pe_tree #(.N(PW), .IW(PIW)) u_tree (
    .vec   (tree_in),
    .found (tree_found),
    .idx   (tree_idx)
  );

  always_comb begin
    if (MSB_FIRST) sel_idx = IDX_W'(WIDTH - 1) - tree_idx[IDX_W-1:0];
    else           sel_idx = tree_idx[IDX_W-1:0];
  end

  // An empty vector has nothing to clear, so clearing bit sel_idx is harmless.
  always_comb begin
    vec_clr          = vec;
    vec_clr[sel_idx] = 1'b0;
  end

  assign out_none  = ~tree_found;
  assign out_idx   = out_none ? '0 : sel_idx;
  assign out_last  = out_none || !all_r || ~|vec_clr;
  assign out_valid = (state == BUSY);
  assign out_cnt   = cnt;
  assign in_ready  = (state == IDLE) && rst;
  assign load      = in_valid && in_ready;
  assign accept    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load) state_nxt = BUSY;
        BUSY:    if (accept && out_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vec   <= '0;
      all_r <= 1'b0;
      cnt   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      vec   <= in_vec;
      all_r <= in_all;
      cnt   <= '0;
    end else if (accept) begin
      vec <= vec_clr;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_priority_encoder_iter.sv
// Scoreboard bench for priority_encoder_iter: four instances (16/10 bits, LSB/MSB first)
// share stimulus; a negedge monitor checks every presented result against the queue.

module tb_priority_encoder_iter;
  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] idx;
    logic       none;
    logic       last;
    logic [4:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, out_ready, all_in;
  logic [15:0] vec_in;
  logic [3:0]  vld_in, rdy, o_valid, o_none, o_last;
  logic [3:0]  o_idx [4];
  logic [4:0]  o_cnt [4];

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  priority_encoder_iter #(.WIDTH(16), .MSB_FIRST(1'b0)) u_l16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(vld_in[0]), .in_ready(rdy[0]),
    .in_vec(vec_in), .in_all(all_in), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_idx(o_idx[0]), .out_none(o_none[0]), .out_last(o_last[0]), .out_cnt(o_cnt[0]));
  priority_encoder_iter #(.WIDTH(16), .MSB_FIRST(1'b1)) u_m16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(vld_in[1]), .in_ready(rdy[1]),
    .in_vec(vec_in), .in_all(all_in), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_idx(o_idx[1]), .out_none(o_none[1]), .out_last(o_last[1]), .out_cnt(o_cnt[1]));
  priority_encoder_iter #(.WIDTH(10), .MSB_FIRST(1'b0)) u_l10 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(vld_in[2]), .in_ready(rdy[2]),
    .in_vec(vec_in[9:0]), .in_all(all_in), .out_valid(o_valid[2]), .out_ready(out_ready),
    .out_idx(o_idx[2]), .out_none(o_none[2]), .out_last(o_last[2]), .out_cnt(o_cnt[2]));
  priority_encoder_iter #(.WIDTH(10), .MSB_FIRST(1'b1)) u_m10 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(vld_in[3]), .in_ready(rdy[3]),
    .in_vec(vec_in[9:0]), .in_all(all_in), .out_valid(o_valid[3]), .out_ready(out_ready),
    .out_idx(o_idx[3]), .out_none(o_none[3]), .out_last(o_last[3]), .out_cnt(o_cnt[3]));

  // Compare every presented result with the queue head; pop when it is consumed or aborted.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (o_valid[d]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_result dut%0d: got idx=%0d none=%0b last=%0b cnt=%0d, expected no result",
                   d, o_idx[d], o_none[d], o_last[d], o_cnt[d]);
        end else begin
          mon_e = sb[0];
          if (mon_e.dut != 2'(d) || mon_e.idx != o_idx[d] || mon_e.none != o_none[d] ||
              mon_e.last != o_last[d] || mon_e.cnt != o_cnt[d]) begin
            n_fail++;
            $display("[TB] FAIL result dut%0d: got idx=%0d none=%0b last=%0b cnt=%0d, expected dut%0d idx=%0d none=%0b last=%0b cnt=%0d",
                     d, o_idx[d], o_none[d], o_last[d], o_cnt[d],
                     mon_e.dut, mon_e.idx, mon_e.none, mon_e.last, mon_e.cnt);
          end
          if (out_ready || flush || !rst) void'(sb.pop_front());
        end
        n_cmp++;
        if (int'(o_cnt[d]) >= ((d < 2) ? 16 : 10)) begin
          n_fail++;
          $display("[TB] FAIL cnt_saturation dut%0d: got cnt=%0d, expected below width", d, o_cnt[d]);
        end
      end
    end
  end

  task automatic check_output(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int dut, input int idx, input bit none, input bit last, input int cnt);
    exp_t e;
    e.dut  = 2'(dut);
    e.idx  = 4'(idx);
    e.none = none;
    e.last = last;
    e.cnt  = 5'(cnt);
    sb.push_back(e);
  endtask

  // Presents one request when the instance is ready and holds in_valid for exactly one edge.
  task automatic apply_stimulus(input int dut, input logic [15:0] v, input logic a);
    int t;
    t = 0;
    while (!rdy[dut] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rdy[dut]) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL in_ready_timeout dut%0d: got in_ready=0, expected 1 within 50 cycles", dut);
    end
    vec_in      = v;
    all_in      = a;
    vld_in[dut] = 1'b1;
    @(posedge clk); #1;
    vld_in[dut] = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(posedge clk); #2;
      t++;
    end while ((sb.size() != 0 || o_valid != 4'b0) && t < 100);
    if (sb.size() != 0 || o_valid != 4'b0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; all_in = 1'b0;
    vec_in = '0; vld_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("in_ready_in_reset", int'(rdy[0]), 0);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      check_output("reset_in_ready", int'(rdy[d]), 1);
      check_output("reset_out_valid", int'(o_valid[d]), 0);
      check_output("reset_out_cnt", int'(o_cnt[d]), 0);
    end
    @(posedge clk); #1;

    // All-mode, LSB first
    push_exp(0, 0, 0, 0, 0); push_exp(0, 5, 0, 0, 1);
    push_exp(0, 10, 0, 0, 2); push_exp(0, 15, 0, 1, 3);
    apply_stimulus(0, 16'h8421, 1'b1);
    wait_done();
    check_output("in_ready_after_last", int'(rdy[0]), 1);

    // Single winner, MSB first, and LSB-first counterpart
    push_exp(1, 11, 0, 1, 0);
    apply_stimulus(1, 16'h0F00, 1'b0);
    wait_done();
    push_exp(0, 8, 0, 1, 0);
    apply_stimulus(0, 16'h0F00, 1'b0);
    wait_done();

    // Empty vector in both modes
    push_exp(0, 0, 1, 1, 0);
    apply_stimulus(0, 16'h0000, 1'b1);
    wait_done();
    push_exp(1, 0, 1, 1, 0);
    apply_stimulus(1, 16'h0000, 1'b0);
    wait_done();

    // All-mode, MSB first
    push_exp(1, 15, 0, 0, 0); push_exp(1, 10, 0, 0, 1);
    push_exp(1, 5, 0, 0, 2); push_exp(1, 0, 0, 1, 3);
    apply_stimulus(1, 16'h8421, 1'b1);
    wait_done();

    // Backpressure: first result held for three stalled cycles
    out_ready = 1'b0;
    push_exp(0, 1, 0, 0, 0); push_exp(0, 2, 0, 1, 1);
    apply_stimulus(0, 16'h0006, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check_output("bp_idx_hold", int'(o_idx[0]), 1);
      check_output("bp_last_hold", int'(o_last[0]), 0);
    end
    out_ready = 1'b1;
    wait_done();

    // Flush together with the second accept
    push_exp(0, 4, 0, 0, 0); push_exp(0, 5, 0, 0, 1);
    apply_stimulus(0, 16'h00F0, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("flush_out_valid", int'(o_valid[0]), 0);
    check_output("flush_in_ready", int'(rdy[0]), 1);
    check_output("flush_out_cnt", int'(o_cnt[0]), 0);
    repeat (3) @(posedge clk);
    wait_done();

    // Flush in IDLE discards a simultaneous load
    flush = 1'b1;
    apply_stimulus(0, 16'h0001, 1'b1);
    flush = 1'b0;
    check_output("idle_flush_out_valid", int'(o_valid[0]), 0);
    check_output("idle_flush_in_ready", int'(rdy[0]), 1);
    repeat (3) @(posedge clk);
    #1;

    // Reset in place of the second accept
    push_exp(0, 4, 0, 0, 0); push_exp(0, 5, 0, 0, 1);
    apply_stimulus(0, 16'h00F0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("rst_in_ready_low", int'(rdy[0]), 0);
    rst = 1'b1;
    #1;
    check_output("rst_out_valid", int'(o_valid[0]), 0);
    check_output("rst_in_ready", int'(rdy[0]), 1);
    check_output("rst_out_cnt", int'(o_cnt[0]), 0);
    repeat (3) @(posedge clk);
    wait_done();

    // Non-power-of-4 width: padding must never be reported
    push_exp(2, 9, 0, 1, 0);
    apply_stimulus(2, 16'h0200, 1'b1);
    wait_done();
    push_exp(3, 9, 0, 1, 0);
    apply_stimulus(3, 16'h0200, 1'b1);
    wait_done();
    push_exp(2, 0, 0, 0, 0); push_exp(2, 9, 0, 1, 1);
    apply_stimulus(2, 16'h0201, 1'b1);
    wait_done();
    push_exp(3, 9, 0, 0, 0); push_exp(3, 0, 0, 1, 1);
    apply_stimulus(3, 16'h0201, 1'b1);
    wait_done();
    push_exp(2, 0, 0, 1, 0);
    apply_stimulus(2, 16'h03FF, 1'b0);
    wait_done();
    push_exp(3, 9, 0, 1, 0);
    apply_stimulus(3, 16'h03FF, 1'b0);
    wait_done();

    check_output("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
